line_fifo_sequencer: RTL and testbench

Phase controller and access arbiter for the shared 16-bit line FIFO in the nonogram solver.
- Sequences the board through RECEIVE → SOLVE → FLUSH → TRANSMIT.
- Grants FIFO writes to the parser or the solver according to phase, and gates solver reads.
- Tracks FIFO occupancy and counts solver passes (one pass = one full sweep of the lines queued at pass start).
- Sits between parser, solver, assembler and the FIFO IP; replaces ad-hoc muxing and reset logic at top level.

---
 rtl/line_fifo_sequencer.sv | 133 +++++++++++++
 tb/tb_line_fifo_sequencer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/line_fifo_sequencer.sv
// Phase controller and access arbiter for the shared line FIFO of the nonogram solver.
// Sequences RECEIVE/SOLVE/FLUSH/TRANSMIT, muxes FIFO writers, gates reads and counts passes.
module line_fifo_sequencer #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 1024,
    localparam int unsigned OW = $clog2(DEPTH + 1)
) (
    input  logic             clk_50mhz,
    input  logic             rst,
    input  logic             parsed_i,
    input  logic             solved_i,
    input  logic             assembled_i,
    input  logic             parse_valid_i,
    input  logic [WIDTH-1:0] parse_data_i,
    output logic             parse_ready_o,
    input  logic             solve_valid_i,
    input  logic [WIDTH-1:0] solve_data_i,
    output logic             solve_ready_o,
    input  logic             rd_req_i,
    output logic             rd_grant_o,
    output logic [WIDTH-1:0] fifo_din_o,
    output logic             fifo_wr_en_o,
    output logic             fifo_rd_en_o,
    output logic             fifo_srst_o,
    input  logic             fifo_full_i,
    input  logic             fifo_empty_i,
    output logic [1:0]       phase_o,
    output logic [OW-1:0]    occupancy_o,
    output logic             pass_done_o,
    output logic [7:0]       pass_count_o,
    output logic             protocol_err_o
);

    typedef enum logic [1:0] {
        StReceive  = 2'd0,
        StSolve    = 2'd1,
        StTransmit = 2'd2,
        StFlush    = 2'd3
    } phase_e;

    phase_e        phase_q, phase_d;
    logic [OW-1:0] occ_q, occ_d;
    logic [OW-1:0] pass_len_q;
    logic [OW-1:0] rd_cnt_q;
    logic          pass_done_q;
    logic [7:0]    pass_count_q;
    logic          err_q;

    logic in_receive, in_solve;
    logic wr_parse, wr_solve, rd_fire, pass_end;

    // Handshakes are additionally gated by rst so nothing fires while the FIFO is held in reset.
    assign in_receive = ~rst & (phase_q == StReceive);
    assign in_solve   = ~rst & (phase_q == StSolve);

    assign parse_ready_o = in_receive & ~fifo_full_i;
    assign solve_ready_o = in_solve & ~fifo_full_i;
    assign wr_parse      = parse_valid_i & parse_ready_o;
    assign wr_solve      = solve_valid_i & solve_ready_o;
    assign fifo_wr_en_o  = wr_parse | wr_solve;
    assign fifo_din_o    = (phase_q == StReceive) ? parse_data_i : solve_data_i;

    assign rd_fire      = rd_req_i & in_solve & ~fifo_empty_i;
    assign rd_grant_o   = rd_fire;
    assign fifo_rd_en_o = rd_fire;
    assign fifo_srst_o  = rst | (phase_q == StFlush);

    assign pass_end = rd_fire & (pass_len_q != '0) & ((rd_cnt_q + OW'(1)) == pass_len_q);

    always_comb begin
        phase_d = phase_q;
        unique case (phase_q)
            StReceive:  if (parsed_i) phase_d = StSolve;
            StSolve:    if (solved_i) phase_d = StFlush;
            StFlush:    phase_d = StTransmit;
            StTransmit: if (assembled_i) phase_d = StReceive;
        endcase
    end

    always_comb begin
        occ_d = occ_q;
        if (fifo_wr_en_o && !rd_fire) begin
            occ_d = occ_q + OW'(1);
        end else if (rd_fire && !fifo_wr_en_o) begin
            occ_d = occ_q - OW'(1);
        end
        // A write issued together with solved is discarded by the flush reset.
        if (phase_q == StFlush || phase_d == StFlush) begin
            occ_d = '0;
        end
    end

    always_ff @(posedge clk_50mhz) begin
        if (rst) begin
            phase_q      <= StReceive;
            occ_q        <= '0;
            pass_len_q   <= '0;
            rd_cnt_q     <= '0;
            pass_done_q  <= 1'b0;
            pass_count_q <= 8'd0;
            err_q        <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            occ_q       <= occ_d;
            pass_done_q <= pass_end;
            if (phase_q == StReceive && phase_d == StSolve) begin
                pass_len_q   <= occ_d;
                rd_cnt_q     <= '0;
                pass_count_q <= 8'd0;
            end else if (pass_end) begin
                // Words put back during this pass become the next pass.
                pass_len_q <= occ_d;
                rd_cnt_q   <= '0;
                if (pass_count_q != 8'hFF) begin
                    pass_count_q <= pass_count_q + 8'd1;
                end
            end else if (rd_fire) begin
                rd_cnt_q <= rd_cnt_q + OW'(1);
            end
            if ((parse_valid_i && phase_q != StReceive) ||
                (solve_valid_i && phase_q != StSolve)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign phase_o        = phase_q;
    assign occupancy_o    = occ_q;
    assign pass_done_o    = pass_done_q;
    assign pass_count_o   = pass_count_q;
    assign protocol_err_o = err_q;

endmodule

// File: tb/tb_line_fifo_sequencer.sv
// Directed bench for line_fifo_sequencer: a 16-deep instance for phase/pass checks and
// a 4-deep instance for the full-FIFO checks, both sharing the same stimulus.
module tb_line_fifo_sequencer;

    logic clk_50mhz = 1'b0;
    always #10 clk_50mhz = ~clk_50mhz;

    logic        rst, parsed, solved, assembled;
    logic        parse_valid, solve_valid, rd_req, fifo_full, fifo_empty;
    logic [15:0] parse_data, solve_data;

    logic        parse_ready, solve_ready, rd_grant, fifo_wr_en, fifo_rd_en, fifo_srst;
    logic        pass_done, protocol_err;
    logic [15:0] fifo_din;
    logic [1:0]  phase;
    logic [4:0]  occupancy;
    logic [7:0]  pass_count;

    logic        s_parse_ready, s_solve_ready, s_rd_grant, s_fifo_wr_en, s_fifo_rd_en;
    logic        s_fifo_srst, s_pass_done, s_protocol_err;
    logic [15:0] s_fifo_din;
    logic [1:0]  s_phase;
    logic [2:0]  s_occupancy;
    logic [7:0]  s_pass_count;

    int checks = 0;
    int errors = 0;

    // Solve-phase vectors: per cycle read request, put-back, then expected registered results.
    bit rd_v   [9] = '{1, 1, 0, 1, 1, 1, 1, 1, 1};
    bit sv_v   [9] = '{0, 1, 1, 0, 1, 0, 0, 0, 0};
    int occ_v  [9] = '{4, 4, 5, 4, 4, 3, 2, 1, 0};
    bit done_v [9] = '{0, 0, 0, 0, 0, 1, 0, 0, 1};
    int cnt_v  [9] = '{0, 0, 0, 0, 0, 1, 1, 1, 2};

    line_fifo_sequencer #(.WIDTH(16), .DEPTH(16)) u_dut (
        .clk_50mhz     (clk_50mhz),
        .rst           (rst),
        .parsed_i      (parsed),
        .solved_i      (solved),
        .assembled_i   (assembled),
        .parse_valid_i (parse_valid),
        .parse_data_i  (parse_data),
        .parse_ready_o (parse_ready),
        .solve_valid_i (solve_valid),
        .solve_data_i  (solve_data),
        .solve_ready_o (solve_ready),
        .rd_req_i      (rd_req),
        .rd_grant_o    (rd_grant),
        .fifo_din_o    (fifo_din),
        .fifo_wr_en_o  (fifo_wr_en),
        .fifo_rd_en_o  (fifo_rd_en),
        .fifo_srst_o   (fifo_srst),
        .fifo_full_i   (fifo_full),
        .fifo_empty_i  (fifo_empty),
        .phase_o       (phase),
        .occupancy_o   (occupancy),
        .pass_done_o   (pass_done),
        .pass_count_o  (pass_count),
        .protocol_err_o(protocol_err)
    );

    line_fifo_sequencer #(.WIDTH(16), .DEPTH(4)) u_dut4 (
        .clk_50mhz     (clk_50mhz),
        .rst           (rst),
        .parsed_i      (parsed),
        .solved_i      (solved),
        .assembled_i   (assembled),
        .parse_valid_i (parse_valid),
        .parse_data_i  (parse_data),
        .parse_ready_o (s_parse_ready),
        .solve_valid_i (solve_valid),
        .solve_data_i  (solve_data),
        .solve_ready_o (s_solve_ready),
        .rd_req_i      (rd_req),
        .rd_grant_o    (s_rd_grant),
        .fifo_din_o    (s_fifo_din),
        .fifo_wr_en_o  (s_fifo_wr_en),
        .fifo_rd_en_o  (s_fifo_rd_en),
        .fifo_srst_o   (s_fifo_srst),
        .fifo_full_i   (fifo_full),
        .fifo_empty_i  (fifo_empty),
        .phase_o       (s_phase),
        .occupancy_o   (s_occupancy),
        .pass_done_o   (s_pass_done),
        .pass_count_o  (s_pass_count),
        .protocol_err_o(s_protocol_err)
    );

    task automatic tick;
        @(posedge clk_50mhz);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; parse_valid = 1'b1; rd_req = 1'b1; fifo_empty = 1'b0;
        tick(); tick();
        checks++; if (phase !== 2'd0) begin errors++; $display("FAIL rst_phase got %0d want 0", phase); end
        checks++; if (occupancy !== 5'd0) begin errors++; $display("FAIL rst_occ got %0d want 0", occupancy); end
        checks++; if (pass_done !== 1'b0) begin errors++; $display("FAIL rst_pass_done got %b want 0", pass_done); end
        checks++; if (pass_count !== 8'd0) begin errors++; $display("FAIL rst_pass_count got %0d want 0", pass_count); end
        checks++; if (protocol_err !== 1'b0) begin errors++; $display("FAIL rst_err got %b want 0", protocol_err); end
        checks++; if (fifo_srst !== 1'b1) begin errors++; $display("FAIL rst_srst got %b want 1", fifo_srst); end
        checks++; if (parse_ready !== 1'b0) begin errors++; $display("FAIL rst_parse_ready got %b want 0", parse_ready); end
        checks++; if (fifo_wr_en !== 1'b0) begin errors++; $display("FAIL rst_wr_en got %b want 0", fifo_wr_en); end
        checks++; if (rd_grant !== 1'b0) begin errors++; $display("FAIL rst_rd_grant got %b want 0", rd_grant); end
        parse_valid = 1'b0; rd_req = 1'b0; fifo_empty = 1'b1; rst = 1'b0;
        tick();
        checks++; if (fifo_srst !== 1'b0) begin errors++; $display("FAIL post_rst_srst got %b want 0", fifo_srst); end
        checks++; if (parse_ready !== 1'b1) begin errors++; $display("FAIL post_rst_parse_ready got %b want 1", parse_ready); end
    endtask

    task automatic test_receive;
        for (int i = 0; i < 5; i++) begin
            parse_valid = 1'b1;
            parse_data  = 16'hA000 + 16'(i);
            solve_valid = (i == 1);
            parsed      = (i == 4);
            #1;
            checks++; if (fifo_wr_en !== 1'b1) begin errors++; $display("FAIL recv_wr_en[%0d] got %b want 1", i, fifo_wr_en); end
            checks++; if (fifo_din !== 16'hA000 + 16'(i)) begin errors++; $display("FAIL recv_din[%0d] got %h want %h", i, fifo_din, 16'hA000 + 16'(i)); end
            checks++; if (solve_ready !== 1'b0) begin errors++; $display("FAIL recv_solve_ready[%0d] got %b want 0", i, solve_ready); end
            if (i == 2) begin
                checks++; if (protocol_err !== 1'b1) begin errors++; $display("FAIL recv_err got %b want 1", protocol_err); end
            end
            tick();
            checks++; if (occupancy !== 5'(i + 1)) begin errors++; $display("FAIL recv_occ[%0d] got %0d want %0d", i, occupancy, i + 1); end
        end
        parse_valid = 1'b0; parsed = 1'b0; solve_valid = 1'b0;
        checks++; if (phase !== 2'd1) begin errors++; $display("FAIL recv_to_solve got %0d want 1", phase); end
        checks++; if (pass_count !== 8'd0) begin errors++; $display("FAIL recv_pass_count got %0d want 0", pass_count); end
    endtask

    task automatic test_solve_passes;
        fifo_empty = 1'b0;
        for (int c = 0; c < 9; c++) begin
            rd_req      = rd_v[c];
            solve_valid = sv_v[c];
            solve_data  = 16'hB000 + 16'(c);
            #1;
            checks++; if (rd_grant !== rd_v[c]) begin errors++; $display("FAIL solve_grant[%0d] got %b want %b", c, rd_grant, rd_v[c]); end
            checks++; if (fifo_rd_en !== rd_v[c]) begin errors++; $display("FAIL solve_rd_en[%0d] got %b want %b", c, fifo_rd_en, rd_v[c]); end
            checks++; if (fifo_wr_en !== sv_v[c]) begin errors++; $display("FAIL solve_wr_en[%0d] got %b want %b", c, fifo_wr_en, sv_v[c]); end
            checks++; if (fifo_din !== 16'hB000 + 16'(c)) begin errors++; $display("FAIL solve_din[%0d] got %h want %h", c, fifo_din, 16'hB000 + 16'(c)); end
            tick();
            checks++; if (occupancy !== 5'(occ_v[c])) begin errors++; $display("FAIL solve_occ[%0d] got %0d want %0d", c, occupancy, occ_v[c]); end
            checks++; if (pass_done !== done_v[c]) begin errors++; $display("FAIL solve_pass_done[%0d] got %b want %b", c, pass_done, done_v[c]); end
            checks++; if (pass_count !== 8'(cnt_v[c])) begin errors++; $display("FAIL solve_pass_count[%0d] got %0d want %0d", c, pass_count, cnt_v[c]); end
        end
        solve_valid = 1'b0; rd_req = 1'b1; fifo_empty = 1'b1;
        #1;
        checks++; if (rd_grant !== 1'b0) begin errors++; $display("FAIL empty_grant got %b want 0", rd_grant); end
        rd_req = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick();
            checks++; if (pass_done !== 1'b0) begin errors++; $display("FAIL idle_pass_done[%0d] got %b want 0", k, pass_done); end
        end
        checks++; if (pass_count !== 8'd2) begin errors++; $display("FAIL idle_pass_count got %0d want 2", pass_count); end
    endtask

    task automatic test_flush_transmit;
        solve_valid = 1'b1; solve_data = 16'hC0DE; solved = 1'b1;
        #1;
        checks++; if (fifo_wr_en !== 1'b1) begin errors++; $display("FAIL flush_wr_en got %b want 1", fifo_wr_en); end
        tick();
        solve_valid = 1'b0; solved = 1'b0;
        checks++; if (phase !== 2'd3) begin errors++; $display("FAIL flush_phase got %0d want 3", phase); end
        checks++; if (fifo_srst !== 1'b1) begin errors++; $display("FAIL flush_srst got %b want 1", fifo_srst); end
        checks++; if (occupancy !== 5'd0) begin errors++; $display("FAIL flush_occ got %0d want 0", occupancy); end
        tick();
        checks++; if (phase !== 2'd2) begin errors++; $display("FAIL xmit_phase got %0d want 2", phase); end
        checks++; if (fifo_srst !== 1'b0) begin errors++; $display("FAIL xmit_srst got %b want 0", fifo_srst); end
        parsed = 1'b1; tick(); parsed = 1'b0;
        checks++; if (phase !== 2'd2) begin errors++; $display("FAIL xmit_ignore_parsed got %0d want 2", phase); end
        assembled = 1'b1; tick(); assembled = 1'b0;
        checks++; if (phase !== 2'd0) begin errors++; $display("FAIL assembled_phase got %0d want 0", phase); end
    endtask

    task automatic test_rst_mid_solve;
        for (int i = 0; i < 7; i++) begin
            parse_valid = 1'b1; parse_data = 16'h7000 + 16'(i); parsed = (i == 6);
            tick();
        end
        parse_valid = 1'b0; parsed = 1'b0;
        checks++; if (phase !== 2'd1) begin errors++; $display("FAIL mid_phase got %0d want 1", phase); end
        checks++; if (occupancy !== 5'd7) begin errors++; $display("FAIL mid_occ got %0d want 7", occupancy); end
        checks++; if (pass_count !== 8'd0) begin errors++; $display("FAIL mid_pass_count got %0d want 0", pass_count); end
        checks++; if (protocol_err !== 1'b1) begin errors++; $display("FAIL mid_err_sticky got %b want 1", protocol_err); end
        rst = 1'b1; tick();
        checks++; if (phase !== 2'd0) begin errors++; $display("FAIL mid_rst_phase got %0d want 0", phase); end
        checks++; if (occupancy !== 5'd0) begin errors++; $display("FAIL mid_rst_occ got %0d want 0", occupancy); end
        checks++; if (protocol_err !== 1'b0) begin errors++; $display("FAIL mid_rst_err got %b want 0", protocol_err); end
        checks++; if (fifo_srst !== 1'b1) begin errors++; $display("FAIL mid_rst_srst got %b want 1", fifo_srst); end
        rst = 1'b0; tick();
    endtask

    task automatic test_full_depth4;
        for (int i = 0; i < 4; i++) begin
            parse_valid = 1'b1; parse_data = 16'hD000 + 16'(i);
            tick();
        end
        fifo_full = 1'b1;
        #1;
        checks++; if (s_parse_ready !== 1'b0) begin errors++; $display("FAIL full_parse_ready got %b want 0", s_parse_ready); end
        checks++; if (s_fifo_wr_en !== 1'b0) begin errors++; $display("FAIL full_wr_en got %b want 0", s_fifo_wr_en); end
        tick();
        checks++; if (s_occupancy !== 3'd4) begin errors++; $display("FAIL full_occ got %0d want 4", s_occupancy); end
        parse_valid = 1'b0; parsed = 1'b1; tick(); parsed = 1'b0;
        checks++; if (s_phase !== 2'd1) begin errors++; $display("FAIL full_phase got %0d want 1", s_phase); end
        rd_req = 1'b1; fifo_empty = 1'b0; solve_valid = 1'b1; solve_data = 16'hE123;
        #1;
        checks++; if (s_rd_grant !== 1'b1) begin errors++; $display("FAIL full_rd_grant got %b want 1", s_rd_grant); end
        checks++; if (s_fifo_rd_en !== 1'b1) begin errors++; $display("FAIL full_rd_en got %b want 1", s_fifo_rd_en); end
        checks++; if (s_solve_ready !== 1'b0) begin errors++; $display("FAIL full_solve_ready got %b want 0", s_solve_ready); end
        checks++; if (s_fifo_wr_en !== 1'b0) begin errors++; $display("FAIL full_rw_wr_en got %b want 0", s_fifo_wr_en); end
        checks++; if (s_fifo_din !== 16'hE123) begin errors++; $display("FAIL full_din got %h want e123", s_fifo_din); end
        tick();
        rd_req = 1'b0; fifo_empty = 1'b1; solve_valid = 1'b0; fifo_full = 1'b0;
        checks++; if (s_occupancy !== 3'd3) begin errors++; $display("FAIL full_rw_occ got %0d want 3", s_occupancy); end
        checks++; if (s_pass_done !== 1'b0) begin errors++; $display("FAIL full_pass_done got %b want 0", s_pass_done); end
        checks++; if (s_pass_count !== 8'd0) begin errors++; $display("FAIL full_pass_count got %0d want 0", s_pass_count); end
        checks++; if (s_protocol_err !== 1'b0) begin errors++; $display("FAIL full_err got %b want 0", s_protocol_err); end
        checks++; if (s_fifo_srst !== 1'b0) begin errors++; $display("FAIL full_srst got %b want 0", s_fifo_srst); end
    endtask

    initial begin
        rst = 1'b1; parsed = 1'b0; solved = 1'b0; assembled = 1'b0;
        parse_valid = 1'b0; solve_valid = 1'b0; rd_req = 1'b0;
        fifo_full = 1'b0; fifo_empty = 1'b1;
        parse_data = 16'h0000; solve_data = 16'h0000;
        test_reset();
        test_receive();
        test_solve_passes();
        test_flush_transmit();
        test_rst_mid_solve();
        test_full_depth4();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
